// File: rtl/byte_joining_param.sv
// Lane de-striping byte joiner: buffers LANES-wide symbol groups in a FIFO and
// serialises each group lane 0 first, up to its stored active-lane index.
module byte_joining_param #(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 2,
    parameter int unsigned AW    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] lanes_in,
    input  logic [CW-1:0]          active_lanes,
    input  logic                   lanes_valid,
    output logic                   lanes_ready,
    output logic [WIDTH-1:0]       out_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CW-1:0]          lane_idx,
    output logic [AW:0]            fifo_count,
    output logic                   group_done
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [CW-1:0] MAX_LANE = CW'(LANES - 1);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [LANES*WIDTH-1:0] mem_lanes [DEPTH];
    logic [CW-1:0]          mem_act   [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [CW-1:0] lane_idx_q;

    logic          push, pop, last_lane, pop_group;
    logic [CW-1:0] act_clamped;
    logic [CW-1:0] head_act;

    assign head_act  = mem_act[rd_ptr_q];
    assign push      = lanes_valid & lanes_ready;
    assign pop       = out_valid & out_ready;
    assign last_lane = (lane_idx_q == head_act);
    assign pop_group = pop & last_lane;

    // Only matters when LANES is not a power of two.
    assign act_clamped = (active_lanes > MAX_LANE) ? MAX_LANE : active_lanes;

    // Storage is deliberately left unreset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_lanes[wr_ptr_q] <= lanes_in;
            mem_act[wr_ptr_q]   <= act_clamped;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_idx_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                if (last_lane) begin
                    lane_idx_q <= '0;
                    rd_ptr_q   <= rd_ptr_q + 1'b1;
                end else begin
                    lane_idx_q <= lane_idx_q + 1'b1;
                end
            end
            unique case ({push, pop_group})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        lanes_ready = (count_q != FULL_COUNT);
        out_valid   = (count_q != '0);
        lane_idx    = lane_idx_q;
        fifo_count  = count_q;
        group_done  = pop_group;
        out_byte    = '0;
        if (out_valid) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (lane_idx_q == CW'(i)) begin
                    out_byte = mem_lanes[rd_ptr_q][i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_joining_param.sv
// Directed self-checking bench for byte_joining_param (LANES=4, WIDTH=8, AW=2).
module tb_byte_joining_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lanes_in;
    logic [1:0]  active_lanes;
    logic        lanes_valid;
    logic        lanes_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  lane_idx;
    logic [2:0]  fifo_count;
    logic        group_done;

    int total = 0;
    int bad   = 0;

    byte_joining_param #(
        .LANES(4),
        .WIDTH(8),
        .CW(2),
        .AW(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .lanes_in(lanes_in),
        .active_lanes(active_lanes),
        .lanes_valid(lanes_valid),
        .lanes_ready(lanes_ready),
        .out_byte(out_byte),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .lane_idx(lane_idx),
        .fifo_count(fifo_count),
        .group_done(group_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to the next negedge; inputs set here are sampled at the following posedge.
    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic out_chk(input string tag, input logic [7:0] b, input logic [1:0] idx,
                           input logic gd);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".byte"}, 32'(out_byte), 32'(b));
        chk({tag, ".idx"}, 32'(lane_idx), 32'(idx));
        chk({tag, ".gd"}, 32'(group_done), 32'(gd));
    endtask

    logic [7:0] exp_seq [20];

    initial begin
        reset        = 1'b1;
        lanes_in     = '0;
        active_lanes = '0;
        lanes_valid  = 1'b0;
        out_ready    = 1'b0;
        next();
        chk("rst.count", 32'(fifo_count), 32'd0);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.ready", 32'(lanes_ready), 32'd1);
        chk("rst.byte", 32'(out_byte), 32'd0);
        chk("rst.idx", 32'(lane_idx), 32'd0);
        chk("rst.gd", 32'(group_done), 32'd0);
        reset = 1'b0;

        // 1: single x4 group
        next();
        lanes_in = 32'h44332211; active_lanes = 2'd3; lanes_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("t1.pre_valid", 32'(out_valid), 32'd0);
        next();
        lanes_valid = 1'b0;
        #1;
        chk("t1.count1", 32'(fifo_count), 32'd1);
        out_chk("t1.b0", 8'h11, 2'd0, 1'b0);
        next(); out_chk("t1.b1", 8'h22, 2'd1, 1'b0);
        next(); out_chk("t1.b2", 8'h33, 2'd2, 1'b0);
        next(); out_chk("t1.b3", 8'h44, 2'd3, 1'b1);
        next();
        chk("t1.empty_valid", 32'(out_valid), 32'd0);
        chk("t1.count0", 32'(fifo_count), 32'd0);
        chk("t1.empty_byte", 32'(out_byte), 32'd0);

        // 2: mixed widths x1 then x2
        lanes_in = 32'h000000A0; active_lanes = 2'd0; lanes_valid = 1'b1;
        next();
        lanes_in = 32'hB3B2B1B0; active_lanes = 2'd1;
        #1;
        out_chk("t2.a0", 8'hA0, 2'd0, 1'b1);
        next();
        lanes_valid = 1'b0;
        #1;
        out_chk("t2.b0", 8'hB0, 2'd0, 1'b0);
        next(); out_chk("t2.b1", 8'hB1, 2'd1, 1'b1);
        next();
        chk("t2.done", 32'(out_valid), 32'd0);

        // 3 + 5: fill under backpressure, then drain with a pop colliding with a full push
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) exp_seq[k*4+j] = 8'(16 * (k + 1) + j);
        end
        for (int k = 0; k < 4; k++) begin
            lanes_in = {exp_seq[k*4+3], exp_seq[k*4+2], exp_seq[k*4+1], exp_seq[k*4]};
            active_lanes = 2'd3; lanes_valid = 1'b1;
            next();
        end
        lanes_in = {exp_seq[19], exp_seq[18], exp_seq[17], exp_seq[16]};
        #1;
        chk("t3.full_ready", 32'(lanes_ready), 32'd0);
        chk("t3.full_count", 32'(fifo_count), 32'd4);
        next();
        chk("t3.held_count", 32'(fifo_count), 32'd4);
        chk("t3.held_byte", 32'(out_byte), 32'h10);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("t3.seq%0d", i), 32'(out_byte), 32'(exp_seq[i]));
            chk($sformatf("t3.gd%0d", i), 32'(group_done), 32'((i % 4) == 3));
            if (i == 3) begin
                chk("t5.refuse_ready", 32'(lanes_ready), 32'd0);
                chk("t5.refuse_count", 32'(fifo_count), 32'd4);
            end
            if (i == 4) begin
                chk("t5.accept_ready", 32'(lanes_ready), 32'd1);
                chk("t5.accept_count", 32'(fifo_count), 32'd3);
            end
            if (i == 5) begin
                chk("t5.after_count", 32'(fifo_count), 32'd4);
            end
            next();
            if (i == 4) lanes_valid = 1'b0;
        end
        chk("t3.drained", 32'(out_valid), 32'd0);

        // 4: mid-group stall
        lanes_in = 32'h44332211; active_lanes = 2'd3; lanes_valid = 1'b1;
        next();
        lanes_valid = 1'b0;
        #1;
        out_chk("t4.b0", 8'h11, 2'd0, 1'b0);
        next(); out_chk("t4.b1", 8'h22, 2'd1, 1'b0);
        next();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            out_chk($sformatf("t4.hold%0d", i), 8'h33, 2'd2, 1'b0);
            next();
        end
        out_ready = 1'b1;
        #1;
        out_chk("t4.b2", 8'h33, 2'd2, 1'b0);
        next(); out_chk("t4.b3", 8'h44, 2'd3, 1'b1);
        next();

        // 6: async reset between edges, mid-group
        lanes_in = 32'h44332211; active_lanes = 2'd3; lanes_valid = 1'b1;
        next();
        lanes_valid = 1'b0;
        next();
        chk("t6.pre_byte", 32'(out_byte), 32'h22);
        #1;
        reset = 1'b1;
        #1;
        chk("t6.valid", 32'(out_valid), 32'd0);
        chk("t6.count", 32'(fifo_count), 32'd0);
        chk("t6.idx", 32'(lane_idx), 32'd0);
        reset = 1'b0;
        next();
        lanes_in = 32'h00006655; active_lanes = 2'd1; lanes_valid = 1'b1;
        next();
        lanes_valid = 1'b0;
        #1;
        out_chk("t6.b0", 8'h55, 2'd0, 1'b0);
        next(); out_chk("t6.b1", 8'h66, 2'd1, 1'b1);
        next();
        chk("t6.done", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/byte_joining_param.md
Name: byte_joining_param

Overview:
- Parametrised next-generation byte joiner (lane de-striping stage) for the physical-layer receive path.
- Accepts one parallel group of LANES lanes, WIDTH bits each, per handshake, plus a per-group active-lane count (link width x1..xLANES).
- Buffers groups in an internal FIFO and serialises them as one WIDTH-bit stream, lane 0 first.
- Uses valid/ready handshakes on both sides and generates its own lane counter.

Parameters:
LANES, 4, number of physical lanes (>=1)
WIDTH, 8, bits per lane symbol
CW, 2, lane-index width; must equal clog2(LANES), minimum 1
AW, 2, FIFO address width; depth DEPTH = 2**AW groups

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
lanes_in  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
active_lanes  in  CW  highest active lane index (n = n+1 lanes); sampled with lanes_in
lanes_valid  in  1  input group valid
lanes_ready  out  1  FIFO can accept a group
out_byte  out  WIDTH  serialised lane symbol
out_valid  out  1  out_byte valid
out_ready  in  1  downstream accepts out_byte
lane_idx  out  CW  lane currently presented on out_byte
fifo_count  out  AW+1  groups stored, including the head being serialised
group_done  out  1  combinational strobe: last lane of a group accepted this cycle

Behaviour:
- Reset (async assert, takes effect immediately): fifo_count=0, read/write pointers=0, lane_idx=0, out_valid=0, out_byte=0, lanes_ready=1, group_done=0. FIFO storage is not reset.
- Push: lanes_valid & lanes_ready at a clk edge writes {clamped active_lanes, lanes_in} at the write pointer. The write pointer wraps modulo DEPTH.
- Clamping: active_lanes > LANES-1 is stored as LANES-1 (only reachable when LANES is not a power of 2).
- lanes_ready = (fifo_count != DEPTH). It is derived from registered state only. When full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (fifo_count != 0).
- out_byte = head.lanes[lane_idx] when out_valid, else 0. This is combinational from registered state.
- Latency: a group pushed into an empty FIFO at edge k is presented from edge k (out_valid=1 in the cycle after the push cycle).
- Pop/advance on out_valid & out_ready:
  - if lane_idx == head.active: lane_idx<=0, read pointer increments (wrap), group_done=1 that cycle;
  - else lane_idx<=lane_idx+1.
- Lanes above head.active are never emitted.
- out_ready=0: out_byte, lane_idx, and the head entry are held stable. No symbol is dropped or repeated.
- Simultaneous push and pop (not full): fifo_count unchanged, both pointers advance.
- fifo_count is a true count (0..DEPTH); pointers are AW bits wide.
- Output ordering is strict FIFO: group order first, then lane 0..active within each group.
- x1 groups (active=0): one byte per group; group_done fires on every accepted byte.
- Reset mid-group: discards all buffered and partially serialised groups. The first group after release starts at lane 0.
- Throughput: one symbol per cycle when out_ready=1 and FIFO non-empty, with no bubble between groups.

Test Plan:
1. Reset, push lanes_in lane0..3 = 11,22,33,44 (hex) with active=3, out_ready=1 -> out_byte 11,22,33,44 on 4 consecutive cycles; lane_idx 0,1,2,3; group_done only on 44; fifo_count 1 then 0.
2. Mixed widths: push group A (active=0, lane0=A0), then B (active=1, lanes B0,B1,B2,B3) -> output exactly A0,B0,B1; group_done on A0 and B1; B2/B3 never appear.
3. Backpressure: out_ready=0, offer 5 x4 groups -> 4 accepted, lanes_ready=0, fifo_count=4, 5th held at input; then out_ready=1 -> 20 bytes in order, 5th group accepted once a slot frees.
4. Mid-group stall: x4 group 11..44, out_ready=0 for 3 cycles after 2 bytes accepted -> out_byte=33, lane_idx=2 held; resumes with 33,44.
5. Full plus simultaneous pop: FIFO full, out_ready=1 on last lane, lanes_valid=1 -> push refused that cycle, fifo_count 4->3, push accepted next cycle; no symbol lost.
6. Async reset asserted between clk edges mid-group -> out_valid=0, fifo_count=0, lane_idx=0 immediately; after release, new group 55,66 (active=1) -> out 55,66.
